apb_protocol_monitor: RTL and testbench
=======================================

Name: apb_protocol_monitor

Overview:
Parametrised, synthesisable APB3 protocol monitor. It attaches passively to one APB requester/completer link and tracks each transfer through a SETUP/ACCESS state machine. It flags protocol violations, wait-state timeouts and missing slave errors in sticky flags, and counts completed reads, writes and errors. It replaces ad-hoc simulation-only checks so the same checks can run in emulation and silicon debug.

Parameters:
ADDR_W, 32, width of paddr
DATA_W, 32, width of pwdata/prdata
MAX_WAIT, 15, maximum ACCESS cycles with pready low before timeout
RO_ADDR, 32'h0000_0004, read-only register address, compared under ADDR_MASK
WO_ADDR, 32'h0000_0008, write-only register address, compared under ADDR_MASK
ADDR_MASK, 32'h0000_FFFF, bits of paddr used for RO_ADDR/WO_ADDR compare
ADDR_LIMIT, 32'h0001_0000, addresses >= this are out of range
CNT_W, 16, width of the statistics counters

Ports:
pclk  in  1  APB clock
presetn  in  1  asynchronous active-low reset
psel  in  1  APB select
penable  in  1  APB enable
pwrite  in  1  1 = write
paddr  in  ADDR_W  address
pwdata  in  DATA_W  write data
prdata  in  DATA_W  read data (observed only)
pready  in  1  completer ready
pslverr  in  1  completer error
clr_flags  in  1  synchronous clear of err_flags and counters
err_flags  out  8  sticky violation flags
err_pulse  out  1  one-cycle pulse when any flag bit newly sets
xfer_done  out  1  one-cycle pulse per completed transfer
wr_count  out  CNT_W  completed writes, saturating
rd_count  out  CNT_W  completed reads, saturating
err_count  out  CNT_W  completed transfers with pslverr=1, saturating

Behaviour:
- All outputs are registered and update on the pclk edge following the sampled condition. presetn=0 forces the FSM to IDLE and all outputs and internal registers to 0, including during a transfer in progress. The first edge after reset release samples normally.
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE -> SETUP on psel=1, penable=0.
  - SETUP -> ACCESS unconditionally. The SETUP cycle captures paddr, pwrite and pwdata, and clears wait_cnt.
  - ACCESS with pready=1 completes the transfer. Next state is SETUP if the same cycle also shows psel=1, penable=0 (not legal APB, so this also raises flag 0), otherwise IDLE.
  - ACCESS with pready=0 stays in ACCESS and increments wait_cnt. wait_cnt saturates at MAX_WAIT+1.
- err_flags bits (each is sticky):
  - [0] SETUP_SEQ: in SETUP the next cycle lacks psel=1 and penable=1. The FSM still moves to ACCESS if psel=1; if psel=0 it returns to IDLE.
  - [1] EN_NO_SEL: penable=1 while psel=0, in any state.
  - [2] UNSTABLE: in ACCESS, paddr or pwrite differs from the captured value, or pwdata differs on a write.
  - [3] TIMEOUT: wait_cnt reaches MAX_WAIT with pready still 0. Raised at most once per transfer. Monitoring continues.
  - [4] RO_NOERR: completed write with (paddr&ADDR_MASK)==RO_ADDR and pslverr=0.
  - [5] WO_NOERR: completed read with (paddr&ADDR_MASK)==WO_ADDR and pslverr=0.
  - [6] OOR_NOERR: completed transfer with paddr>=ADDR_LIMIT and pslverr=0.
  - [7] ERR_NO_READY: pslverr=1 while not (ACCESS and pready=1).
- err_pulse = OR of bits that move 0->1 in that update.
- On completion: xfer_done=1 for one cycle. Then wr_count++ if pwrite, else rd_count++. err_count++ if pslverr=1. Counters hold at all-ones.
- clr_flags=1 clears flags and counters. A flag set or count increment in the same cycle wins: the result is that bit set or the count equal to 1.
- Back-to-back transfers (IDLE skipped) must not lose a count. Zero-wait ACCESS completes with 2-cycle transfer latency.

Test Plan:
- Reset mid-ACCESS with wait_cnt=5: presetn low 1 cycle -> all outputs 0, FSM IDLE. The next legal write is counted with wr_count=1.
- Write 0x0000_0010 with 0 waits, then read with 3 waits -> 2 xfer_done pulses, wr_count=1, rd_count=1, err_flags=0.
- Read with pready low for 15 ACCESS cycles (MAX_WAIT=15) -> err_flags[3]=1 and a single err_pulse. The read completes later and rd_count=1.
- Write to 0x0000_0004 with pslverr=0 -> err_flags[4]=1. Write to 0x0002_0000 with pslverr=1 -> no flag, err_count=1.
- paddr changes during a waited ACCESS and penable is driven with psel=0 -> err_flags = 8'h06. clr_flags coincident with a new EN_NO_SEL leaves 8'h02.
- 65 536 writes with CNT_W=16 -> wr_count saturates at 16'hFFFF.

Source files
------------

// File: rtl/apb_protocol_monitor_if.sv
// APB3 link bundle shared by a requester, a completer and any passive
// observers of the same link.
//   psel/penable/pwrite/paddr/pwdata : driven by the requester
//   prdata/pready/pslverr            : driven by the completer
// Modports: master (requester side), slave (completer side) and monitor
// (everything as inputs, for blocks that only watch the link).
interface apb_protocol_monitor_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );

  modport monitor (
    input psel, penable, pwrite, paddr, pwdata, prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_protocol_monitor.sv
// Passive APB3 protocol monitor. Follows each transfer through an
// IDLE/SETUP/ACCESS state machine, raises sticky violation flags and keeps
// saturating statistics of completed reads, writes and slave errors.
// Ports:
//   pclk, presetn   clock and asynchronous active-low reset
//   apb             observed APB link (monitor modport, all inputs)
//   clr_flags       synchronous clear of err_flags and the counters
//   err_flags[7:0]  sticky flags: 0 SETUP_SEQ, 1 EN_NO_SEL, 2 UNSTABLE,
//                   3 TIMEOUT, 4 RO_NOERR, 5 WO_NOERR, 6 OOR_NOERR,
//                   7 ERR_NO_READY
//   err_pulse       one-cycle pulse when any flag bit newly sets
//   xfer_done       one-cycle pulse per completed transfer
//   wr_count, rd_count, err_count   saturating completion counters
// All outputs are registered.
module apb_protocol_monitor #(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                MAX_WAIT   = 15,
  parameter logic [ADDR_W-1:0] RO_ADDR    = 32'h0000_0004,
  parameter logic [ADDR_W-1:0] WO_ADDR    = 32'h0000_0008,
  parameter logic [ADDR_W-1:0] ADDR_MASK  = 32'h0000_FFFF,
  parameter logic [ADDR_W-1:0] ADDR_LIMIT = 32'h0001_0000,
  parameter int                CNT_W      = 16
) (
  input  logic                   pclk,
  input  logic                   presetn,
  apb_protocol_monitor_if.monitor apb,
  input  logic                   clr_flags,
  output logic [7:0]             err_flags,
  output logic                   err_pulse,
  output logic                   xfer_done,
  output logic [CNT_W-1:0]       wr_count,
  output logic [CNT_W-1:0]       rd_count,
  output logic [CNT_W-1:0]       err_count
);

  localparam int                WAIT_W    = $clog2(MAX_WAIT + 2);
  localparam logic [WAIT_W-1:0] WAIT_SAT  = WAIT_W'(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  // SETUP means a setup cycle has been captured and the cycle now on the
  // bus is the first access cycle; ACCESS means at least one wait state has
  // already passed.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [7:0]        flags_q, flags_d;
  logic              pulse_q, pulse_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

  logic [7:0] flag_set;
  logic       setup_seen;
  logic       in_access;
  logic       ro_hit;
  logic       wo_hit;
  logic       oor_hit;

  // Clear has lower priority than an increment in the same cycle, so a
  // coincident completion leaves the counter at exactly one.
  function automatic logic [CNT_W-1:0] next_cnt(input logic [CNT_W-1:0] cur,
                                                input logic inc,
                                                input logic clr);
    if (clr) return inc ? CNT_W'(1) : '0;
    if (inc && (cur != '1)) return cur + CNT_W'(1);
    return cur;
  endfunction

  assign setup_seen = apb.psel && !apb.penable;
  assign in_access  = (state_q == ACCESS) || ((state_q == SETUP) && apb.psel);
  assign ro_hit     = (addr_q & ADDR_MASK) == RO_ADDR;
  assign wo_hit     = (addr_q & ADDR_MASK) == WO_ADDR;
  assign oor_hit    = addr_q >= ADDR_LIMIT;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wr_d       = wr_q;
    wdata_d    = wdata_q;
    wait_cnt_d = wait_cnt_q;
    flag_set   = '0;
    done_d     = 1'b0;

    if (apb.penable && !apb.psel) flag_set[1] = 1'b1;
    if (apb.pslverr && !(in_access && apb.pready)) flag_set[7] = 1'b1;

    case (state_q)
      IDLE: begin
        if (setup_seen) begin
          addr_d     = apb.paddr;
          wr_d       = apb.pwrite;
          wdata_d    = apb.pwdata;
          wait_cnt_d = '0;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        if (!(apb.psel && apb.penable)) flag_set[0] = 1'b1;
        if (!apb.psel) state_d = IDLE;
      end
      default: ;
    endcase

    // Every access cycle, the first one included, checks stability and
    // either completes the transfer or counts one more wait state.
    if (in_access) begin
      if ((apb.paddr != addr_q) || (apb.pwrite != wr_q) ||
          (wr_q && (apb.pwdata != wdata_q))) begin
        flag_set[2] = 1'b1;
      end
      if (apb.pready) begin
        done_d = 1'b1;
        if (wr_q && ro_hit && !apb.pslverr) flag_set[4] = 1'b1;
        if (!wr_q && wo_hit && !apb.pslverr) flag_set[5] = 1'b1;
        if (oor_hit && !apb.pslverr) flag_set[6] = 1'b1;
        if (setup_seen) begin
          flag_set[0] = 1'b1;
          addr_d      = apb.paddr;
          wr_d        = apb.pwrite;
          wdata_d     = apb.pwdata;
          wait_cnt_d  = '0;
          state_d     = SETUP;
        end else begin
          state_d = IDLE;
        end
      end else begin
        state_d = ACCESS;
        if (wait_cnt_q != WAIT_SAT) wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        // The counter only passes this value once per transfer, so the
        // timeout flag fires at most once.
        if (wait_cnt_q == WAIT_LAST) flag_set[3] = 1'b1;
      end
    end

    flags_d   = (clr_flags ? 8'h00 : flags_q) | flag_set;
    pulse_d   = |(flags_d & ~flags_q);
    wr_cnt_d  = next_cnt(wr_cnt_q, done_d && wr_q, clr_flags);
    rd_cnt_d  = next_cnt(rd_cnt_q, done_d && !wr_q, clr_flags);
    err_cnt_d = next_cnt(err_cnt_q, done_d && apb.pslverr, clr_flags);
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      wait_cnt_q <= '0;
      flags_q    <= '0;
      pulse_q    <= 1'b0;
      done_q     <= 1'b0;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wr_q       <= wr_d;
      wdata_q    <= wdata_d;
      wait_cnt_q <= wait_cnt_d;
      flags_q    <= flags_d;
      pulse_q    <= pulse_d;
      done_q     <= done_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign err_flags = flags_q;
  assign err_pulse = pulse_q;
  assign xfer_done = done_q;
  assign wr_count  = wr_cnt_q;
  assign rd_count  = rd_cnt_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_apb_protocol_monitor.sv
// Bench for apb_protocol_monitor. Drives whole APB transfers and single
// protocol-abuse cycles, and predicts the monitor's flags, pulse counts and
// counters from the transfer-level rules. A second instance with 4-bit
// counters watches the same link so counter saturation is reachable quickly.
module tb_apb_protocol_monitor;

  localparam int          MAX_WAIT   = 15;
  localparam logic [31:0] RO_ADDR    = 32'h0000_0004;
  localparam logic [31:0] WO_ADDR    = 32'h0000_0008;
  localparam logic [31:0] ADDR_MASK  = 32'h0000_FFFF;
  localparam logic [31:0] ADDR_LIMIT = 32'h0001_0000;

  logic        pclk = 1'b0;
  logic        presetn;
  logic        clr_flags;
  logic [7:0]  err_flags, err_flags_s;
  logic        err_pulse, err_pulse_s;
  logic        xfer_done, xfer_done_s;
  logic [15:0] wr_count, rd_count, err_count;
  logic [3:0]  wr_count_s, rd_count_s, err_count_s;

  apb_protocol_monitor_if #(.ADDR_W(32), .DATA_W(32)) apb ();

  apb_protocol_monitor #(.CNT_W(16)) dut (
    .pclk      (pclk),
    .presetn   (presetn),
    .apb       (apb),
    .clr_flags (clr_flags),
    .err_flags (err_flags),
    .err_pulse (err_pulse),
    .xfer_done (xfer_done),
    .wr_count  (wr_count),
    .rd_count  (rd_count),
    .err_count (err_count)
  );

  apb_protocol_monitor #(.CNT_W(4)) dut_small (
    .pclk      (pclk),
    .presetn   (presetn),
    .apb       (apb),
    .clr_flags (clr_flags),
    .err_flags (err_flags_s),
    .err_pulse (err_pulse_s),
    .xfer_done (xfer_done_s),
    .wr_count  (wr_count_s),
    .rd_count  (rd_count_s),
    .err_count (err_count_s)
  );

  always #5 pclk = ~pclk;

  int n_compared = 0;
  int n_mismatched = 0;

  // Reference state: completion counts since the last clear/reset, the
  // expected flag word and running totals of expected/observed pulses.
  logic [7:0] exp_flags = 8'h00;
  int n_wr = 0, n_rd = 0, n_err = 0;
  int exp_xfers = 0, exp_pulses = 0;
  int obs_xfers = 0, obs_pulses = 0, obs_xfers_s = 0, obs_pulses_s = 0;

  logic [31:0] addr_pool [8] = '{32'h0000_0010, 32'h0000_0004, 32'h0000_0008,
                                 32'h0002_0000, 32'h0001_0004, 32'h0001_0008,
                                 32'h0000_0100, 32'h0000_FFFC};

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic int sat(input int n, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  // One clock: outputs are sampled 1 time unit after the rising edge, and
  // the caller changes inputs from that point on.
  task automatic step();
    @(posedge pclk);
    #1;
    if (xfer_done) obs_xfers++;
    if (err_pulse) obs_pulses++;
    if (xfer_done_s) obs_xfers_s++;
    if (err_pulse_s) obs_pulses_s++;
  endtask

  task automatic busIdle();
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
    apb.pready  = 1'b0;
    apb.pslverr = 1'b0;
    clr_flags   = 1'b0;
  endtask

  // Flag bits raised together on one clock edge give one pulse at most.
  task automatic raise(input logic [7:0] bits);
    if ((bits & ~exp_flags) != 8'h00) exp_pulses++;
    exp_flags = exp_flags | bits;
  endtask

  function automatic logic [7:0] completionFlags(input bit wr, input logic [31:0] a,
                                                 input bit e);
    logic [7:0] f;
    f = 8'h00;
    if (!e) begin
      if (wr && ((a & ADDR_MASK) == RO_ADDR)) f[4] = 1'b1;
      if (!wr && ((a & ADDR_MASK) == WO_ADDR)) f[5] = 1'b1;
      if (a >= ADDR_LIMIT) f[6] = 1'b1;
    end
    return f;
  endfunction

  task automatic modelReset();
    exp_flags = 8'h00;
    n_wr = 0;
    n_rd = 0;
    n_err = 0;
  endtask

  // One complete transfer: setup, 'waits' cycles with pready low, then the
  // completing cycle. 'glitch' moves paddr during the first wait state.
  task automatic applyStimulus(input bit wr, input logic [31:0] a, input logic [31:0] d,
                               input int waits, input bit e, input bit glitch);
    apb.psel    = 1'b1;
    apb.penable = 1'b0;
    apb.pwrite  = wr;
    apb.paddr   = a;
    apb.pwdata  = d;
    apb.pready  = 1'b0;
    apb.pslverr = 1'b0;
    apb.prdata  = $urandom;
    step();
    for (int i = 0; i < waits; i++) begin
      apb.penable = 1'b1;
      apb.paddr   = (glitch && i == 0) ? (a ^ 32'h0000_0040) : a;
      step();
    end
    apb.penable = 1'b1;
    apb.paddr   = a;
    apb.pready  = 1'b1;
    apb.pslverr = e;
    step();
    busIdle();
    if (glitch && waits > 0) raise(8'h04);
    if (waits >= MAX_WAIT) raise(8'h08);
    raise(completionFlags(wr, a, e));
    exp_xfers++;
    if (wr) n_wr++;
    else n_rd++;
    if (e) n_err++;
  endtask

  task automatic enNoSel();
    apb.psel    = 1'b0;
    apb.penable = 1'b1;
    step();
    busIdle();
    raise(8'h02);
  endtask

  task automatic errIdle();
    apb.pslverr = 1'b1;
    step();
    busIdle();
    raise(8'h80);
  endtask

  task automatic abortSetup();
    apb.psel    = 1'b1;
    apb.penable = 1'b0;
    apb.pwrite  = 1'b0;
    apb.paddr   = 32'h0000_0010;
    step();
    apb.psel = 1'b0;
    step();
    busIdle();
    raise(8'h01);
  endtask

  task automatic doClear(input bit with_en);
    logic [7:0] nf;
    clr_flags   = 1'b1;
    apb.psel    = 1'b0;
    apb.penable = with_en;
    step();
    busIdle();
    nf = with_en ? 8'h02 : 8'h00;
    if ((nf & ~exp_flags) != 8'h00) exp_pulses++;
    exp_flags = nf;
    n_wr = 0;
    n_rd = 0;
    n_err = 0;
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ":err_flags"}, 32'(err_flags), 32'(exp_flags));
    checkOutput({tag, ":wr_count"}, 32'(wr_count), sat(n_wr, 16));
    checkOutput({tag, ":rd_count"}, 32'(rd_count), sat(n_rd, 16));
    checkOutput({tag, ":err_count"}, 32'(err_count), sat(n_err, 16));
    checkOutput({tag, ":xfer_pulses"}, obs_xfers, exp_xfers);
    checkOutput({tag, ":err_pulses"}, obs_pulses, exp_pulses);
    checkOutput({tag, ":small_flags"}, 32'(err_flags_s), 32'(exp_flags));
    checkOutput({tag, ":small_wr"}, 32'(wr_count_s), sat(n_wr, 4));
    checkOutput({tag, ":small_rd"}, 32'(rd_count_s), sat(n_rd, 4));
    checkOutput({tag, ":small_err"}, 32'(err_count_s), sat(n_err, 4));
    checkOutput({tag, ":small_xfers"}, obs_xfers_s, exp_xfers);
    checkOutput({tag, ":small_pulses"}, obs_pulses_s, exp_pulses);
  endtask

  task automatic checkZero(input string tag);
    checkOutput({tag, ":err_flags"}, 32'(err_flags), 32'h0);
    checkOutput({tag, ":err_pulse"}, 32'(err_pulse), 32'h0);
    checkOutput({tag, ":xfer_done"}, 32'(xfer_done), 32'h0);
    checkOutput({tag, ":wr_count"}, 32'(wr_count), 32'h0);
    checkOutput({tag, ":rd_count"}, 32'(rd_count), 32'h0);
    checkOutput({tag, ":err_count"}, 32'(err_count), 32'h0);
  endtask

  initial begin
    int op;
    int waits;
    presetn    = 1'b0;
    apb.pwrite = 1'b0;
    apb.paddr  = '0;
    apb.pwdata = '0;
    apb.prdata = '0;
    busIdle();
    repeat (2) step();
    presetn = 1'b1;
    checkZero("reset");

    // Zero-wait write followed by a three-wait read.
    applyStimulus(1'b1, 32'h0000_0010, 32'hCAFE_0001, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0000_0010, 32'h0, 3, 1'b0, 1'b0);
    checkAll("wr_then_rd");

    // Reset in the middle of a waited access, then a clean write.
    applyStimulus(1'b1, 32'h0000_0020, 32'h1234_5678, 1, 1'b0, 1'b0);
    apb.psel    = 1'b1;
    apb.penable = 1'b0;
    apb.pwrite  = 1'b0;
    apb.paddr   = 32'h0000_0010;
    step();
    apb.penable = 1'b1;
    repeat (5) step();
    #2;
    presetn = 1'b0;
    #1;
    checkZero("async_reset");
    step();
    checkZero("held_reset");
    presetn = 1'b1;
    busIdle();
    modelReset();
    applyStimulus(1'b1, 32'h0000_0030, 32'hA5A5_5A5A, 0, 1'b0, 1'b0);
    checkAll("after_reset");

    // Wait-state timeout on a read that still completes later.
    doClear(1'b0);
    applyStimulus(1'b0, 32'h0000_0010, 32'h0, MAX_WAIT, 1'b0, 1'b0);
    checkAll("timeout");

    // Write to the read-only address, then an out-of-range write with error.
    doClear(1'b0);
    applyStimulus(1'b1, 32'h0000_0004, 32'h1, 0, 1'b0, 1'b0);
    checkAll("ro_write");
    applyStimulus(1'b1, 32'h0002_0000, 32'h2, 1, 1'b1, 1'b0);
    checkAll("oor_err");

    // Unstable address plus enable-without-select, then clear racing a new one.
    doClear(1'b0);
    applyStimulus(1'b0, 32'h0000_0010, 32'h0, 2, 1'b0, 1'b1);
    enNoSel();
    checkAll("unstable_ens");
    doClear(1'b1);
    checkAll("clr_race");

    // Back-to-back writes: the 4-bit instance saturates.
    doClear(1'b0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 32'h0000_0010, $urandom, 0, 1'b0, 1'b0);
    checkAll("saturate");

    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 99);
      if (op < 65) begin
        waits = ($urandom_range(0, 9) == 0) ? $urandom_range(MAX_WAIT - 1, MAX_WAIT + 2)
                                            : $urandom_range(0, 3);
        applyStimulus(1'($urandom_range(0, 1)), addr_pool[$urandom_range(0, 7)], $urandom,
                      waits, ($urandom_range(0, 9) < 3), ($urandom_range(0, 6) == 0));
      end else if (op < 72) begin
        enNoSel();
      end else if (op < 78) begin
        errIdle();
      end else if (op < 85) begin
        abortSetup();
      end else if (op < 92) begin
        doClear(1'($urandom_range(0, 1)));
      end else begin
        repeat ($urandom_range(1, 3)) step();
      end
      checkAll("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
